// File: rtl/rvfi_pkg.sv
// ============================================================================
// Module : rvfi_pkg
// Brief  : Shared types and defaults for the RVFI commit tracker.
//          commit_t is the record held per buffered commit. PC and
//          rd_wdata fields are sized for the widest supported XLEN
//          (XLEN_MAX); narrower builds zero-extend on entry and take
//          the low XLEN bits on exit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvfi_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NRET_DEFAULT = 2;
  localparam int XLEN_MAX     = 64;
  localparam int ORDER_W      = 64;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [31:0]         inst;
    logic [XLEN_MAX-1:0] pc_rdata;
    logic [XLEN_MAX-1:0] pc_wdata;
    logic [4:0]          rd_addr;
    logic [XLEN_MAX-1:0] rd_wdata;
    logic                trap;
    logic                halt;
  } commit_t;

endpackage

`default_nettype wire

// File: rtl/commit_fifo.sv
// ============================================================================
// Module : commit_fifo
// Brief  : Circular buffer of commit_t with up to NRET writes and one read
//          per cycle. Writes are presented compacted: wr_data[0..wr_cnt-1]
//          are stored in that order at the write pointer.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          wr_cnt        - number of entries to store this cycle
//          wr_data       - compacted entries, slot 0 oldest
//          rd_en         - pop the head (caller guarantees count != 0)
//          rd_data       - head entry, stable until popped
//          count, free   - occupancy and space available this cycle
//                          (free already credits a same-cycle pop)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_fifo
  import rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int NW   = $clog2(NRET + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] wr_cnt,
  input  commit_t       wr_data [NRET],
  input  logic          rd_en,
  output commit_t       rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  commit_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (NW'(k) < wr_cnt) begin
        mem[wr_ptr + AW'(k)] <= wr_data[k];
      end
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain modular addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(wr_cnt) - CW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign free    = CW'(DEPTH) - count + CW'(rd_en);

endmodule

`default_nettype wire

// File: rtl/rvfi_commit_tracker.sv
// ============================================================================
// Module : rvfi_commit_tracker
// Brief  : Samples up to NRET RVFI retire lanes per cycle, compacts valid
//          lanes (lane 0 oldest), tags each with a 64-bit order number and
//          queues them for a ready/valid consumer. A group that does not
//          fit is dropped whole and flags overflow. Dequeuing a halt
//          (self-loop) entry sets halted, after which lanes are ignored.
// Ports  : clk, rst              - clock, synchronous active-high reset
//          lane_*                - per-lane retire fields (no backpressure)
//          out_valid/out_ready   - head handshake
//          out_*                 - head entry fields, out_halt = halt entry
//          count                 - buffer occupancy
//          overflow, halted,
//          wdog_timeout          - sticky status flags
// Config : RVFI_WATCHDOG_EN - when defined, an idle-cycle watchdog sets
//          wdog_timeout after WDOG_LIMIT consecutive cycles with no valid
//          lane; when undefined wdog_timeout is tied low.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_commit_tracker
  import rvfi_pkg::*;
#(
  parameter int NRET       = NRET_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int WDOG_LIMIT = 1000,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRET-1:0]           lane_valid,
  input  logic [NRET-1:0][31:0]     lane_inst,
  input  logic [NRET-1:0][XLEN-1:0] lane_pc_rdata,
  input  logic [NRET-1:0][XLEN-1:0] lane_pc_wdata,
  input  logic [NRET-1:0][4:0]      lane_rd_addr,
  input  logic [NRET-1:0][XLEN-1:0] lane_rd_wdata,
  input  logic [NRET-1:0]           lane_trap,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_order,
  output logic [31:0]               out_inst,
  output logic [XLEN-1:0]           out_pc_rdata,
  output logic [XLEN-1:0]           out_pc_wdata,
  output logic [4:0]                out_rd_addr,
  output logic [XLEN-1:0]           out_rd_wdata,
  output logic                      out_trap,
  output logic                      out_halt,
  output logic [CW-1:0]             count,
  output logic                      overflow,
  output logic                      halted,
  output logic                      wdog_timeout
);

  localparam int NW = $clog2(NRET + 1);

  logic [NRET-1:0]    lane_live;
  logic [NW-1:0]      prefix [NRET];
  logic [NW-1:0]      n_valid;
  commit_t            lane_entry   [NRET];
  commit_t            packed_entry [NRET];
  commit_t            head;
  logic [CW-1:0]      free;
  logic [ORDER_W-1:0] order_q;
  logic               deq;
  logic               fits;
  logic               accept;
  logic [NW-1:0]      wr_cnt;

  // Once halted, lanes are masked so only draining continues.
  assign lane_live = halted ? '0 : lane_valid;

  // prefix[i] = number of live lanes below i = slot index and order offset.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NRET; i++) begin
      prefix[i] = NW'(cnt);
      if (lane_live[i]) begin
        cnt = cnt + 1;
      end
    end
    n_valid = NW'(cnt);
  end

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      lane_entry[i]          = '0;
      lane_entry[i].order    = order_q + ORDER_W'(prefix[i]);
      lane_entry[i].inst     = lane_inst[i];
      lane_entry[i].pc_rdata = XLEN_MAX'(lane_pc_rdata[i]);
      lane_entry[i].pc_wdata = XLEN_MAX'(lane_pc_wdata[i]);
      lane_entry[i].rd_addr  = lane_rd_addr[i];
      // x0 writes are architecturally invisible; record them as zero.
      lane_entry[i].rd_wdata = (lane_rd_addr[i] == 5'd0) ? '0 : XLEN_MAX'(lane_rd_wdata[i]);
      lane_entry[i].trap     = lane_trap[i];
      lane_entry[i].halt     = (lane_pc_wdata[i] == lane_pc_rdata[i]) && !lane_trap[i];
    end
  end

  // Compaction: slot k takes the live lane whose prefix equals k.
  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      packed_entry[k] = '0;
      for (int i = 0; i < NRET; i++) begin
        if (lane_live[i] && (prefix[i] == NW'(k))) begin
          packed_entry[k] = lane_entry[i];
        end
      end
    end
  end

  assign out_valid = (count != '0);
  assign deq       = out_valid && out_ready;
  assign fits      = (CW'(n_valid) <= free);
  assign accept    = (n_valid != '0) && fits;
  assign wr_cnt    = accept ? n_valid : '0;

  commit_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_cnt  (wr_cnt),
    .wr_data (packed_entry),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count),
    .free    (free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      order_q  <= '0;
      overflow <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (accept) begin
        order_q <= order_q + ORDER_W'(n_valid);
      end
      // Whole group dropped; order_q is left untouched.
      if (!fits) begin
        overflow <= 1'b1;
      end
      if (deq && head.halt) begin
        halted <= 1'b1;
      end
    end
  end

  assign out_order    = head.order;
  assign out_inst     = head.inst;
  assign out_pc_rdata = head.pc_rdata[XLEN-1:0];
  assign out_pc_wdata = head.pc_wdata[XLEN-1:0];
  assign out_rd_addr  = head.rd_addr;
  assign out_rd_wdata = head.rd_wdata[XLEN-1:0];
  assign out_trap     = head.trap;
  assign out_halt     = head.halt;

  // Upper bits of the wide fields are always zero in narrow builds.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{head.pc_rdata[XLEN_MAX-1:XLEN],
                         head.pc_wdata[XLEN_MAX-1:XLEN],
                         head.rd_wdata[XLEN_MAX-1:XLEN]};
  end

`ifdef RVFI_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [WW-1:0] wdog_cnt;

  // Counts idle cycles, saturating at WDOG_LIMIT; frozen after halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt     <= '0;
      wdog_timeout <= 1'b0;
    end else if (!halted) begin
      if (|lane_valid) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt != WW'(WDOG_LIMIT)) begin
        wdog_cnt <= wdog_cnt + WW'(1);
        if (wdog_cnt == WW'(WDOG_LIMIT - 1)) begin
          wdog_timeout <= 1'b1;
        end
      end
    end
  end
`else
  localparam int unused_wdog_limit = WDOG_LIMIT;
  assign wdog_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvfi_commit_tracker.sv
// ============================================================================
// Module : tb_rvfi_commit_tracker
// Brief  : Self-checking bench for rvfi_commit_tracker (NRET=2, DEPTH=8,
//          XLEN=32, WDOG_LIMIT=10). Driven groups push expected entries to
//          a queue; a monitor pops and compares each accepted head entry.
//          Build with RVFI_WATCHDOG_EN to exercise the watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvfi_commit_tracker;

  localparam int NRET       = 2;
  localparam int DEPTH      = 8;
  localparam int XLEN       = 32;
  localparam int WDOG_LIMIT = 10;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NRET-1:0]           lane_valid = '0;
  logic [NRET-1:0][31:0]     lane_inst = '0;
  logic [NRET-1:0][XLEN-1:0] lane_pc_rdata = '0;
  logic [NRET-1:0][XLEN-1:0] lane_pc_wdata = '0;
  logic [NRET-1:0][4:0]      lane_rd_addr = '0;
  logic [NRET-1:0][XLEN-1:0] lane_rd_wdata = '0;
  logic [NRET-1:0]           lane_trap = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [63:0]               out_order;
  logic [31:0]               out_inst;
  logic [XLEN-1:0]           out_pc_rdata;
  logic [XLEN-1:0]           out_pc_wdata;
  logic [4:0]                out_rd_addr;
  logic [XLEN-1:0]           out_rd_wdata;
  logic                      out_trap;
  logic                      out_halt;
  logic [CW-1:0]             count;
  logic                      overflow;
  logic                      halted;
  logic                      wdog_timeout;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(
    .NRET       (NRET),
    .DEPTH      (DEPTH),
    .XLEN       (XLEN),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lane_valid    (lane_valid),
    .lane_inst     (lane_inst),
    .lane_pc_rdata (lane_pc_rdata),
    .lane_pc_wdata (lane_pc_wdata),
    .lane_rd_addr  (lane_rd_addr),
    .lane_rd_wdata (lane_rd_wdata),
    .lane_trap     (lane_trap),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_order     (out_order),
    .out_inst      (out_inst),
    .out_pc_rdata  (out_pc_rdata),
    .out_pc_wdata  (out_pc_wdata),
    .out_rd_addr   (out_rd_addr),
    .out_rd_wdata  (out_rd_wdata),
    .out_trap      (out_trap),
    .out_halt      (out_halt),
    .count         (count),
    .overflow      (overflow),
    .halted        (halted),
    .wdog_timeout  (wdog_timeout)
  );

  typedef struct {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] m_order = '0;
  int          vectors = 0;
  int          miscompares = 0;

  // Scoreboard consumer: an accepted head is popped at the following edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got order %0d, required no entry", out_order);
      end else begin
        mon_e = sb.pop_front();
        if (out_order !== mon_e.order) begin
          miscompares++;
          $display("FAIL head_order: got %0d, required %0d", out_order, mon_e.order);
        end
        vectors++;
        if ({out_inst, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata, out_trap, out_halt} !==
            {mon_e.inst, mon_e.pc_rdata, mon_e.pc_wdata, mon_e.rd_addr, mon_e.rd_wdata, mon_e.trap, mon_e.halt}) begin
          miscompares++;
          $display("FAIL head_fields: got inst=%h pc=%h npc=%h rd=%0d wd=%h trap=%b halt=%b, required inst=%h pc=%h npc=%h rd=%0d wd=%h trap=%b halt=%b",
                   out_inst, out_pc_rdata, out_pc_wdata, out_rd_addr, out_rd_wdata, out_trap, out_halt,
                   mon_e.inst, mon_e.pc_rdata, mon_e.pc_wdata, mon_e.rd_addr, mon_e.rd_wdata, mon_e.trap, mon_e.halt);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  // Drive one lane group for one cycle; pushes expectations when accept=1.
  task automatic put(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                     input bit halt0, input bit accept);
    logic [31:0] pcs [2];
    logic [4:0]  rda;
    exp_t        e;
    int          slot;
    pcs[0] = pc0;
    pcs[1] = pc1;
    slot   = 0;
    for (int i = 0; i < NRET; i++) begin
      rda              = pcs[i][6:2];
      lane_inst[i]     = pcs[i] ^ 32'h0000_0013;
      lane_pc_rdata[i] = pcs[i];
      lane_pc_wdata[i] = (i == 0 && halt0) ? pcs[i] : pcs[i] + 32'd4;
      lane_rd_addr[i]  = rda;
      lane_rd_wdata[i] = ~pcs[i];
      lane_trap[i]     = 1'b0;
      if (v[i] && accept) begin
        e.order    = m_order + 64'(slot);
        e.inst     = pcs[i] ^ 32'h0000_0013;
        e.pc_rdata = pcs[i];
        e.pc_wdata = (i == 0 && halt0) ? pcs[i] : pcs[i] + 32'd4;
        e.rd_addr  = rda;
        e.rd_wdata = (rda == 5'd0) ? 32'd0 : ~pcs[i];
        e.trap     = 1'b0;
        e.halt     = (i == 0 && halt0);
        sb.push_back(e);
        slot++;
      end
    end
    lane_valid = v;
    m_order    = m_order + 64'(slot);
    @(posedge clk); #1;
    lane_valid = '0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    lane_valid = '0;
    out_ready  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_order = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d entries outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d, required 0", count); end
    vectors++;
    if ({overflow, halted, wdog_timeout} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got ovf/halt/wdog=%b, required 000", {overflow, halted, wdog_timeout});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
`ifdef RVFI_WATCHDOG_EN
    repeat (WDOG_LIMIT - 1) @(posedge clk);
    #1;
    vectors++;
    if (wdog_timeout !== 1'b0) begin miscompares++; $display("FAIL wdog_early: got %b, required 0", wdog_timeout); end
    @(posedge clk); #1;
    vectors++;
    if (wdog_timeout !== 1'b1) begin miscompares++; $display("FAIL wdog_limit: got %b, required 1", wdog_timeout); end
    out_ready = 1'b1;
    put(2'b01, 32'h6000_0200, 32'h0, 1'b0, 1'b1);
    drain();
    vectors++;
    if (wdog_timeout !== 1'b1) begin miscompares++; $display("FAIL wdog_sticky: got %b, required 1", wdog_timeout); end
    do_reset();
    vectors++;
    if (wdog_timeout !== 1'b0) begin miscompares++; $display("FAIL wdog_rst_clear: got %b, required 0", wdog_timeout); end
`else
    repeat (WDOG_LIMIT + 2) @(posedge clk);
    #1;
    vectors++;
    if (wdog_timeout !== 1'b0) begin miscompares++; $display("FAIL wdog_disabled: got %b, required 0", wdog_timeout); end
`endif
  endtask

  task automatic test_two_lanes();
    do_reset();
    out_ready = 1'b1;
    put(2'b11, 32'h6000_0100, 32'h6000_0104, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_order !== 64'd0) begin
      miscompares++;
      $display("FAIL two_lane_first: got valid=%b order=%0d, required valid=1 order=0", out_valid, out_order);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_order !== 64'd1) begin
      miscompares++;
      $display("FAIL two_lane_second: got valid=%b order=%0d, required valid=1 order=1", out_valid, out_order);
    end
    drain();
  endtask

  task automatic test_lane1_only();
    do_reset();
    out_ready = 1'b1;
    put(2'b10, 32'h0000_0000, 32'h6000_0004, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_order !== 64'd0 || out_pc_rdata !== 32'h6000_0004) begin
      miscompares++;
      $display("FAIL lane1_only: got valid=%b order=%0d pc=%h, required valid=1 order=0 pc=60000004",
               out_valid, out_order, out_pc_rdata);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lane1_no_gap: got valid=%b, required 0", out_valid); end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      put(2'b11, 32'h6000_1000 + 32'(g * 8), 32'h6000_1004 + 32'(g * 8), 1'b0, 1'b1);
    end
    vectors++;
    if (count !== CW'(8) || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got count=%0d ovf=%b, required count=8 ovf=0", count, overflow);
    end
    put(2'b11, 32'h6000_2000, 32'h6000_2004, 1'b0, 1'b0);
    vectors++;
    if (count !== CW'(8) || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got count=%0d ovf=%b, required count=8 ovf=1", count, overflow);
    end
    drain();
    // The dropped group must not have consumed order numbers.
    put(2'b01, 32'h6000_3000, 32'h0, 1'b0, 1'b1);
    drain();
    vectors++;
    if (overflow !== 1'b1 || count !== '0) begin
      miscompares++;
      $display("FAIL overflow_sticky: got ovf=%b count=%0d, required ovf=1 count=0", overflow, count);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    out_ready = 1'b0;
    put(2'b11, 32'h6000_4000, 32'h6000_4004, 1'b0, 1'b1);
    put(2'b11, 32'h6000_4008, 32'h6000_400c, 1'b0, 1'b1);
    put(2'b11, 32'h6000_4010, 32'h6000_4014, 1'b0, 1'b1);
    put(2'b01, 32'h6000_4018, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (count !== CW'(7)) begin miscompares++; $display("FAIL count_seven: got %0d, required 7", count); end
    out_ready = 1'b1;
    put(2'b11, 32'h6000_4020, 32'h6000_4024, 1'b0, 1'b1);
    vectors++;
    if (count !== CW'(8) || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_deq_enq: got count=%0d ovf=%b, required count=8 ovf=0", count, overflow);
    end
    drain();
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b0;
    put(2'b01, 32'h6000_0040, 32'h0, 1'b1, 1'b1);
    vectors++;
    if (out_halt !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_head: got out_halt=%b halted=%b, required out_halt=1 halted=0", out_halt, halted);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_dequeue: got halted=%b valid=%b, required halted=1 valid=0", halted, out_valid);
    end
    put(2'b11, 32'h6000_0050, 32'h6000_0054, 1'b0, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_ignore: got count=%0d valid=%b ovf=%b, required count=0 valid=0 ovf=0",
               count, out_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    put(2'b11, 32'h6000_0300, 32'h6000_0304, 1'b0, 1'b1);
    vectors++;
    if (count !== CW'(2)) begin miscompares++; $display("FAIL mid_fill: got count=%0d, required 2", count); end
    rst = 1'b1;
    sb.delete();
    m_order = '0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b count=%0d, required valid=0 count=0", out_valid, count);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    put(2'b01, 32'h6000_0400, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (out_order !== 64'd0) begin miscompares++; $display("FAIL mid_order_restart: got %0d, required 0", out_order); end
    drain();
  endtask

  initial begin
    test_reset();
    test_watchdog();
    test_two_lanes();
    test_lane1_only();
    test_overflow();
    test_full_simul();
    test_halt();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
